mmm_result_collector: RTL and testbench

Word-serial back end of the scalable radix-4 Montgomery multiplier. It receives the carry-save result words (sum and carry vectors) shifted out of the last processing element, least significant word first. It resolves them to a non-redundant result T and applies the final conditional subtraction T − N. It then streams the reduced result (< N) out over a valid/ready handshake.

---
 rtl/mmm_result_collector_if.sv | 28 ++
 rtl/mmm_result_collector.sv | 107 ++++++++++
 tb/tb_mmm_result_collector.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/mmm_result_collector_if.sv
// Handshake bundle between the last Montgomery PE and the result collector:
// carry-save result words in, reduced result words out.
interface mmm_result_collector_if #(
  parameter int W = 16
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] SRs_in;
  logic [W-1:0] SRc_in;
  logic [W-1:0] N_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_word;
  logic         out_last;
  logic         sub_done;

  // Collector side
  modport slave (
    input  in_valid, SRs_in, SRc_in, N_in, out_ready,
    output in_ready, out_valid, out_word, out_last, sub_done
  );

  // Producer / consumer side
  modport master (
    output in_valid, SRs_in, SRc_in, N_in, out_ready,
    input  in_ready, out_valid, out_word, out_last, sub_done
  );
endinterface

// File: rtl/mmm_result_collector.sv
// Word-serial back end of the radix-4 Montgomery multiplier: resolves the
// carry-save result to T, computes T - N alongside, then streams whichever
// of the two is the reduced result (< N), LS word first.
module mmm_result_collector #(
  parameter int K = 1024,
  parameter int W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  mmm_result_collector_if.slave  bus
);
  localparam int E  = K / W;
  localparam int IW = (E > 1) ? $clog2(E) : 1;

  typedef enum logic {COLLECT, DRAIN} state_t;

  state_t        state, state_next;
  logic          c, b, sel;
  logic [IW-1:0] wr_idx, rd_idx;
  logic [W-1:0]  t_buf [E];
  logic [W-1:0]  d_buf [E];

  logic [W:0]    add_full;
  logic [W:0]    sub_full;
  logic          accept, out_fire, wr_last, rd_last;

  // Per-word resolve of the carry-save pair and chained trial subtraction
  always_comb begin
    add_full = {1'b0, bus.SRs_in} + {1'b0, bus.SRc_in} + (W+1)'(c);
    sub_full = {1'b0, add_full[W-1:0]} - {1'b0, bus.N_in} - (W+1)'(b);
  end

  assign accept   = bus.in_valid && bus.in_ready;
  assign out_fire = bus.out_valid && bus.out_ready;
  assign wr_last  = (wr_idx == IW'(E - 1));
  assign rd_last  = (rd_idx == IW'(E - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= COLLECT;
    else        state <= state_next;
  end

  // Next state and handshake/output decode from registered state only
  always_comb begin
    state_next    = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_word  = '0;
    bus.out_last  = 1'b0;
    bus.sub_done  = 1'b0;
    case (state)
      COLLECT: begin
        bus.in_ready = 1'b1;
        if (accept && wr_last) state_next = DRAIN;
      end
      DRAIN: begin
        bus.out_valid = 1'b1;
        bus.out_word  = sel ? d_buf[rd_idx] : t_buf[rd_idx];
        bus.out_last  = rd_last;
        bus.sub_done  = sel;
        if (out_fire && rd_last) state_next = COLLECT;
      end
      default: state_next = COLLECT;
    endcase
  end

  // Carry/borrow chain, word indices and final selection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c      <= 1'b0;
      b      <= 1'b0;
      sel    <= 1'b0;
      wr_idx <= '0;
      rd_idx <= '0;
    end else if (state == COLLECT) begin
      if (accept) begin
        c <= add_full[W];
        b <= sub_full[W];
        if (wr_last) begin
          // Bit K of T is the final carry; no final borrow also means T >= N
          sel    <= add_full[W] | ~sub_full[W];
          rd_idx <= '0;
        end else begin
          wr_idx <= wr_idx + IW'(1);
        end
      end
    end else if (out_fire) begin
      if (rd_last) begin
        c      <= 1'b0;
        b      <= 1'b0;
        wr_idx <= '0;
        rd_idx <= '0;
      end else begin
        rd_idx <= rd_idx + IW'(1);
      end
    end
  end

  // Result buffers; contents are don't-care until overwritten by a block
  always_ff @(posedge clk) begin
    if (accept) begin
      t_buf[wr_idx] <= add_full[W-1:0];
      d_buf[wr_idx] <= sub_full[W-1:0];
    end
  end
endmodule

// File: tb/tb_mmm_result_collector.sv
// Directed scoreboard bench for mmm_result_collector at K=8, W=4 (E=2).
module tb_mmm_result_collector;
  localparam int K = 8;
  localparam int W = 4;

  typedef struct packed {
    logic [W-1:0] word;
    logic         last;
    logic         sub;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   fails  = 0;
  exp_t sb[$];

  mmm_result_collector_if #(.W(W)) bus ();

  mmm_result_collector #(.K(K), .W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: compare every completed output handshake against the scoreboard
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_out: got word %0d with empty scoreboard", bus.out_word);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out_word", int'(bus.out_word), int'(e.word));
        check("out_last", int'(bus.out_last), int'(e.last));
        check("sub_done", int'(bus.sub_done), int'(e.sub));
      end
    end
  end

  task automatic send_word(input logic [W-1:0] s, input logic [W-1:0] cv, input logic [W-1:0] n);
    int k;
    bus.SRs_in   = s;
    bus.SRc_in   = cv;
    bus.N_in     = n;
    bus.in_valid = 1'b1;
    k = 0;
    while (!bus.in_ready && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    if (!bus.in_ready) check("accept_wait", int'(bus.in_ready), 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_block(input logic [W-1:0] s0, input logic [W-1:0] s1,
                            input logic [W-1:0] c0, input logic [W-1:0] c1,
                            input logic [W-1:0] n0, input logic [W-1:0] n1,
                            input logic [W-1:0] e0, input logic [W-1:0] e1,
                            input logic sub);
    sb.push_back('{word: e0, last: 1'b0, sub: sub});
    sb.push_back('{word: e1, last: 1'b1, sub: sub});
    check("collect_ready", int'(bus.in_ready), 1);
    send_word(s0, c0, n0);
    send_word(s1, c1, n1);
    check("drain_valid", int'(bus.out_valid), 1);
  endtask

  // Let the block drain at full rate; in_ready must return right after out_last
  task automatic drain_and_turn();
    int k;
    k = 0;
    while (bus.out_valid && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    check("drain_cycles", k, 2);
    check("turnaround_in_ready", int'(bus.in_ready), 1);
    check("sb_empty", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.SRs_in    = '0;
    bus.SRc_in    = '0;
    bus.N_in      = '0;
    bus.out_ready = 1'b1;
    #12;
    check("rst_in_ready",  int'(bus.in_ready), 1);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_out_word",  int'(bus.out_word), 0);
    check("rst_out_last",  int'(bus.out_last), 0);
    check("rst_sub_done",  int'(bus.sub_done), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // T < N: 3+4 = 7, N = 0x0B
    send_block(4'h3, 4'h0, 4'h4, 4'h0, 4'hB, 4'h0, 4'h7, 4'h0, 1'b0);
    drain_and_turn();
    // Carry across words: T = 0x11, T - N = 0x06
    send_block(4'h9, 4'h0, 4'h8, 4'h0, 4'hB, 4'h0, 4'h6, 4'h0, 1'b1);
    drain_and_turn();
    // Overflow into bit K: T = 0x100, N = 0xFF -> 0x01
    send_block(4'hF, 4'hF, 4'h1, 4'h0, 4'hF, 4'hF, 4'h1, 4'h0, 1'b1);
    drain_and_turn();
    // Equality: T = N = 0x0B
    send_block(4'h5, 4'h0, 4'h6, 4'h0, 4'hB, 4'h0, 4'h0, 4'h0, 1'b1);
    drain_and_turn();

    // Back-pressure with a spurious in_valid during DRAIN
    bus.out_ready = 1'b0;
    send_block(4'h9, 4'h0, 4'h8, 4'h0, 4'hB, 4'h0, 4'h6, 4'h0, 1'b1);
    bus.SRs_in   = 4'hF;
    bus.SRc_in   = 4'hF;
    bus.N_in     = 4'h1;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("bp_out_valid", int'(bus.out_valid), 1);
      check("bp_out_word",  int'(bus.out_word), 6);
      check("bp_out_last",  int'(bus.out_last), 0);
      check("bp_in_ready",  int'(bus.in_ready), 0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    drain_and_turn();

    // Reset after word 0 leaves c=1 and wr_idx=1 behind unless cleared
    send_word(4'hF, 4'h1, 4'h0);
    rst_n = 1'b0;
    #2;
    check("midrst_in_ready",  int'(bus.in_ready), 1);
    check("midrst_out_valid", int'(bus.out_valid), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_block(4'h3, 4'h0, 4'h4, 4'h0, 4'hB, 4'h0, 4'h7, 4'h0, 1'b0);
    drain_and_turn();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
